io_control_unit: RTL and testbench

Hardwired control sequencer for the miniSRC datapath. It replaces hand-driven control stimulus with a state machine that performs instruction fetch (PC→MAR, PC increment, memory read with wait states, MDR→IR), then executes the I/O and special-register subset: `in`, `out`, `mfhi`, `mflo`, `nop`, `halt`. It sits beside the `miniSRC` datapath and drives its control ports directly. It reads only the opcode field IR[31:27] back from the datapath.

---
 rtl/io_control_unit.sv | 174 +++++++++++++++++
 tb/tb_io_control_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_control_unit.sv
// io_control_unit: hardwired fetch/execute sequencer for the miniSRC datapath.
// Drives fetch controls (PC->MAR, PC increment, memory read with wait states,
// MDR->IR) and executes the I/O and special-register subset in T3.
module io_control_unit #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [4:0] ir_opcode,
  input  logic       stop,
  output logic       PCout_en,
  output logic       IncPC,
  output logic       PC_en,
  output logic       MARin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       memRead,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IR_en,
  output logic       Gra,
  output logic       Rin,
  output logic       Rout,
  output logic       inPortOut,
  output logic       outPort_en,
  output logic       HIout,
  output logic       LOout,
  output logic [4:0] alu_opcode,
  output logic       run,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_T0      = 4'h1,
    S_T1      = 4'h2,
    S_T2      = 4'h3,
    S_T3      = 4'h4,
    S_MEMWAIT = 4'hC,
    S_HALT    = 4'hF
  } state_t;

  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Counter preload: the remaining MEMWAIT cycles after the first one.
  localparam logic [2:0] WAIT_LOAD = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  state_t     state_q, state_d;
  logic [2:0] wait_q, wait_d;

  // Next-state and wait-counter logic; stop only matters leaving IDLE or T3.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (!stop) state_d = S_T0;
        else       state_d = S_IDLE;
      end
      S_T0: state_d = S_T1;
      S_T1: begin
        wait_d = WAIT_LOAD;
        if (MEM_WAIT > 0) state_d = S_MEMWAIT;
        else              state_d = S_T2;
      end
      S_MEMWAIT: begin
        if (wait_q == 3'd0) state_d = S_T2;
        else                wait_d  = wait_q - 3'd1;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (ir_opcode == OP_HALT) state_d = S_HALT;
        else if (stop)            state_d = S_IDLE;
        else                      state_d = S_T0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter flops; clear forces IDLE without waiting for a clock edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Control decode from the current state; execute strobes depend on the opcode in T3.
  always_comb begin
    PCout_en   = 1'b0;
    IncPC      = 1'b0;
    PC_en      = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    memRead    = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IR_en      = 1'b0;
    Gra        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    inPortOut  = 1'b0;
    outPort_en = 1'b0;
    HIout      = 1'b0;
    LOout      = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_T0: begin
        PCout_en = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        Zin      = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PC_en   = 1'b1;
        memRead = 1'b1;
        MDRin   = 1'b1;
      end
      S_MEMWAIT: begin
        memRead = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IR_en  = 1'b1;
      end
      S_T3: begin
        case (ir_opcode)
          OP_IN: begin
            Gra       = 1'b1;
            Rin       = 1'b1;
            inPortOut = 1'b1;
          end
          OP_OUT: begin
            Gra        = 1'b1;
            Rout       = 1'b1;
            outPort_en = 1'b1;
          end
          OP_MFHI: begin
            Gra   = 1'b1;
            Rin   = 1'b1;
            HIout = 1'b1;
          end
          OP_MFLO: begin
            Gra   = 1'b1;
            Rin   = 1'b1;
            LOout = 1'b1;
          end
          OP_NOP:  illegal = 1'b0;
          OP_HALT: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b0;
    endcase
  end

  assign alu_opcode = OP_NOP;
  assign run        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign state      = state_q;

endmodule

// File: tb/tb_io_control_unit.sv
// Directed testbench for io_control_unit: fetch timing, execute decode,
// halt/illegal handling, stop/clear behaviour and a MEM_WAIT=0 instance.
module tb_io_control_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        clear_b = 1'b1;
  logic        stop = 1'b0;
  logic [4:0]  ir_opcode = 5'b11010;
  logic [31:0] in_port_data = 32'h00000020;
  logic [31:0] target_q = 32'h0;

  logic pcout_en, inc_pc, pc_en, mar_in, z_in, zlow_out, mem_read, mdr_in, mdr_out, ir_en;
  logic gra, rin, rout, in_port_out, out_port_en, hi_out, lo_out, run, illegal;
  logic [4:0] alu_opcode;
  logic [3:0] state;

  logic pcout_en_b, inc_pc_b, pc_en_b, mar_in_b, z_in_b, zlow_out_b, mem_read_b, mdr_in_b;
  logic mdr_out_b, ir_en_b, gra_b, rin_b, rout_b, in_port_out_b, out_port_en_b;
  logic hi_out_b, lo_out_b, run_b, illegal_b;
  logic [4:0] alu_opcode_b;
  logic [3:0] state_b;

  logic [9:0] fetch_v, fetch_v_b;
  logic [6:0] exec_v, exec_v_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign fetch_v   = {pcout_en, inc_pc, pc_en, mar_in, z_in, zlow_out, mem_read, mdr_in, mdr_out, ir_en};
  assign exec_v    = {gra, rin, rout, in_port_out, out_port_en, hi_out, lo_out};
  assign fetch_v_b = {pcout_en_b, inc_pc_b, pc_en_b, mar_in_b, z_in_b, zlow_out_b, mem_read_b,
                      mdr_in_b, mdr_out_b, ir_en_b};
  assign exec_v_b  = {gra_b, rin_b, rout_b, in_port_out_b, out_port_en_b, hi_out_b, lo_out_b};

  always #5 clock = ~clock;

  // Minimal datapath stand-in: target register written from the input port.
  always @(posedge clock) begin
    if (rin && in_port_out) target_q <= in_port_data;
  end

  io_control_unit #(.MEM_WAIT(2)) dut (
    .clock(clock), .clear(clear), .ir_opcode(ir_opcode), .stop(stop),
    .PCout_en(pcout_en), .IncPC(inc_pc), .PC_en(pc_en), .MARin(mar_in), .Zin(z_in),
    .Zlowout(zlow_out), .memRead(mem_read), .MDRin(mdr_in), .MDRout(mdr_out), .IR_en(ir_en),
    .Gra(gra), .Rin(rin), .Rout(rout), .inPortOut(in_port_out), .outPort_en(out_port_en),
    .HIout(hi_out), .LOout(lo_out), .alu_opcode(alu_opcode), .run(run), .illegal(illegal),
    .state(state)
  );

  io_control_unit #(.MEM_WAIT(0)) dut_b (
    .clock(clock), .clear(clear_b), .ir_opcode(ir_opcode), .stop(stop),
    .PCout_en(pcout_en_b), .IncPC(inc_pc_b), .PC_en(pc_en_b), .MARin(mar_in_b), .Zin(z_in_b),
    .Zlowout(zlow_out_b), .memRead(mem_read_b), .MDRin(mdr_in_b), .MDRout(mdr_out_b),
    .IR_en(ir_en_b), .Gra(gra_b), .Rin(rin_b), .Rout(rout_b), .inPortOut(in_port_out_b),
    .outPort_en(out_port_en_b), .HIout(hi_out_b), .LOout(lo_out_b), .alu_opcode(alu_opcode_b),
    .run(run_b), .illegal(illegal_b), .state(state_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for dut to reach state s; a timeout counts as a failed check.
  task automatic wait_state(input logic [3:0] s);
    int n;
    n = 0;
    while (state !== s && n < 30) begin
      step();
      n++;
    end
    total_cnt++;
    if (state !== s) $display("FAIL wait_state: state=%h required=%h (timeout)", state, s);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    step();
    total_cnt++;
    if (state !== 4'h0 || fetch_v !== 10'b0 || exec_v !== 7'b0 || run !== 1'b0 ||
        illegal !== 1'b0 || alu_opcode !== 5'b11010)
      $display("FAIL reset: state=%h fetch=%b exec=%b run=%b ill=%b alu=%b required 0/0/0/0/0/11010",
               state, fetch_v, exec_v, run, illegal, alu_opcode);
    else pass_cnt++;
  endtask

  task automatic test_fetch();
    logic [3:0] exp_s [8];
    logic [9:0] exp_f [8];
    exp_s = '{4'h1, 4'h2, 4'hC, 4'hC, 4'h3, 4'h4, 4'h1, 4'h2};
    exp_f = '{10'b1101100000, 10'b0010011100, 10'b0000001100, 10'b0000001100,
              10'b0000000011, 10'b0000000000, 10'b1101100000, 10'b0010011100};
    ir_opcode = 5'b11010;
    clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total_cnt++;
      if (state !== exp_s[i] || fetch_v !== exp_f[i] || run !== 1'b1 || exec_v !== 7'b0 ||
          illegal !== 1'b0)
        $display("FAIL fetch[%0d]: state=%h fetch=%b run=%b exec=%b ill=%b required %h/%b/1/0/0",
                 i, state, fetch_v, run, exec_v, illegal, exp_s[i], exp_f[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_in();
    wait_state(4'h3);
    ir_opcode = 5'b10110;
    step();
    total_cnt++;
    if (state !== 4'h4 || exec_v !== 7'b1101000 || illegal !== 1'b0)
      $display("FAIL in_t3: state=%h exec=%b ill=%b required 4/1101000/0", state, exec_v, illegal);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 4'h1 || exec_v !== 7'b0 || target_q !== 32'h00000020)
      $display("FAIL in_after: state=%h exec=%b target=%h required 1/0000000/00000020",
               state, exec_v, target_q);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    logic [4:0] ops [3];
    logic [6:0] exp_e [3];
    ops   = '{5'b10111, 5'b11000, 5'b11001};
    exp_e = '{7'b1010100, 7'b1100010, 7'b1100001};
    for (int i = 0; i < 3; i++) begin
      wait_state(4'h3);
      ir_opcode = ops[i];
      step();
      total_cnt++;
      if (state !== 4'h4 || exec_v !== exp_e[i] || illegal !== 1'b0)
        $display("FAIL decode[%b]: state=%h exec=%b ill=%b required 4/%b/0",
                 ops[i], state, exec_v, illegal, exp_e[i]);
      else pass_cnt++;
    end
    ir_opcode = 5'b11010;
  endtask

  task automatic test_illegal();
    wait_state(4'h3);
    ir_opcode = 5'b00101;
    step();
    total_cnt++;
    if (state !== 4'h4 || illegal !== 1'b1 || exec_v !== 7'b0)
      $display("FAIL illegal_t3: state=%h ill=%b exec=%b required 4/1/0", state, illegal, exec_v);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 4'h1 || illegal !== 1'b0)
      $display("FAIL illegal_next: state=%h ill=%b required 1/0", state, illegal);
    else pass_cnt++;
    ir_opcode = 5'b11010;
  endtask

  task automatic test_stop();
    // Short stop pulse that ends before T3 is ignored.
    wait_state(4'hC);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_state(4'h4);
    step();
    total_cnt++;
    if (state !== 4'h1)
      $display("FAIL stop_pulse: state=%h required 1", state);
    else pass_cnt++;
    // Stop held from MEMWAIT through T3: finish instruction then IDLE.
    wait_state(4'hC);
    stop = 1'b1;
    wait_state(4'h4);
    step();
    total_cnt++;
    if (state !== 4'h0 || run !== 1'b0)
      $display("FAIL stop_idle: state=%h run=%b required 0/0", state, run);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 4'h0)
      $display("FAIL stop_hold: state=%h required 0", state);
    else pass_cnt++;
    stop = 1'b0;
    step();
    total_cnt++;
    if (state !== 4'h1 || run !== 1'b1)
      $display("FAIL stop_resume: state=%h run=%b required 1/1", state, run);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    wait_state(4'hC);
    #2;
    clear = 1'b1;
    #1;
    total_cnt++;
    if (state !== 4'h0 || mem_read !== 1'b0 || fetch_v !== 10'b0 || run !== 1'b0)
      $display("FAIL clear_async: state=%h memRead=%b fetch=%b run=%b required 0/0/0/0",
               state, mem_read, fetch_v, run);
    else pass_cnt++;
    step();
    clear = 1'b0;
    step();
    total_cnt++;
    if (state !== 4'h1)
      $display("FAIL clear_release: state=%h required 1", state);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    wait_state(4'h3);
    ir_opcode = 5'b11011;
    step();
    total_cnt++;
    if (state !== 4'h4 || exec_v !== 7'b0 || illegal !== 1'b0)
      $display("FAIL halt_t3: state=%h exec=%b ill=%b required 4/0/0", state, exec_v, illegal);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 4'hF || run !== 1'b0 || fetch_v !== 10'b0)
      $display("FAIL halt_enter: state=%h run=%b fetch=%b required F/0/0", state, run, fetch_v);
    else pass_cnt++;
    ir_opcode = 5'b11010;
    for (int i = 0; i < 5; i++) step();
    total_cnt++;
    if (state !== 4'hF || run !== 1'b0)
      $display("FAIL halt_stay: state=%h run=%b required F/0", state, run);
    else pass_cnt++;
    clear = 1'b1;
    #1;
    total_cnt++;
    if (state !== 4'h0)
      $display("FAIL halt_clear: state=%h required 0", state);
    else pass_cnt++;
  endtask

  task automatic test_memwait0();
    logic [3:0] exp_s [6];
    logic [9:0] exp_f [6];
    exp_s = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
    exp_f = '{10'b1101100000, 10'b0010011100, 10'b0000000011, 10'b0000000000,
              10'b1101100000, 10'b0010011100};
    ir_opcode = 5'b11010;
    step();
    total_cnt++;
    if (state_b !== 4'h0 || run_b !== 1'b0 || fetch_v_b !== 10'b0 || alu_opcode_b !== 5'b11010)
      $display("FAIL mw0_reset: state=%h run=%b fetch=%b alu=%b required 0/0/0/11010",
               state_b, run_b, fetch_v_b, alu_opcode_b);
    else pass_cnt++;
    clear_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (state_b !== exp_s[i] || fetch_v_b !== exp_f[i] || exec_v_b !== 7'b0 ||
          illegal_b !== 1'b0 || run_b !== 1'b1)
        $display("FAIL mw0[%0d]: state=%h fetch=%b exec=%b ill=%b run=%b required %h/%b/0/0/1",
                 i, state_b, fetch_v_b, exec_v_b, illegal_b, run_b, exp_s[i], exp_f[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_in();
    test_decode();
    test_illegal();
    test_stop();
    test_clear();
    test_halt();
    test_memwait0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
